// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at dispatch, marks completions, retires one per cycle
// and discards younger entries on a branch mispredict. Optional counters under ROB_STATS_EN.
module reorder_buffer #(
    parameter int DEPTH  = 32,
    parameter int PREG_W = 7,
    parameter int AREG_W = 5,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alloc_en,
    input  logic [PREG_W-1:0] alloc_pd_new,
    input  logic [PREG_W-1:0] alloc_pd_old,
    input  logic [AREG_W-1:0] alloc_rd,
    input  logic              alloc_has_dest,
    output logic              rob_full,
    output logic [IDX_W-1:0]  rob_index,
    input  logic              alu_done,
    input  logic [IDX_W-1:0]  alu_tag,
    input  logic              b_done,
    input  logic [IDX_W-1:0]  b_tag,
    input  logic              mem_done,
    input  logic [IDX_W-1:0]  mem_tag,
    input  logic              mispredict,
    input  logic [IDX_W-1:0]  mispredict_tag,
    output logic              commit_valid,
    output logic [AREG_W-1:0] commit_rd,
    output logic [PREG_W-1:0] commit_pd_new,
    output logic [PREG_W-1:0] commit_pd_old,
    output logic              commit_free,
    output logic              rob_empty
`ifdef ROB_STATS_EN
    ,
    output logic [31:0]       stat_commits,
    output logic [31:0]       stat_flushed
`endif
);

    logic [DEPTH-1:0]  valid_q, done_q, has_dest_q;
    logic [AREG_W-1:0] rd_q     [DEPTH];
    logic [PREG_W-1:0] pd_new_q [DEPTH];
    logic [PREG_W-1:0] pd_old_q [DEPTH];
    logic [IDX_W-1:0]  head_q, tail_q;
    logic [IDX_W:0]    count_q;

    logic [DEPTH-1:0]  valid_d, done_d, flush_mask, done_hits;
    logic [IDX_W-1:0]  head_d, tail_d, keep_len, offs;
    logic [IDX_W:0]    count_d, keep_cnt;
    logic              alloc_fire;

    assign rob_full      = (count_q == (IDX_W+1)'(DEPTH));
    assign rob_empty     = (count_q == '0);
    assign rob_index     = tail_q;
    assign commit_valid  = valid_q[head_q] && done_q[head_q];
    assign commit_rd     = rd_q[head_q];
    assign commit_pd_new = pd_new_q[head_q];
    assign commit_pd_old = pd_old_q[head_q];
    assign commit_free   = commit_valid && has_dest_q[head_q] && (pd_old_q[head_q] != '0);

    assign alloc_fire = alloc_en && !rob_full && !mispredict;
    assign keep_len   = mispredict_tag - head_q;
    assign keep_cnt   = {1'b0, keep_len} + (IDX_W+1)'(1);
    assign done_hits  = (DEPTH'(alu_done) << alu_tag) | (DEPTH'(b_done) << b_tag) |
                        (DEPTH'(mem_done) << mem_tag);

    // Younger-than-branch is measured as distance from head, so wrap needs no special case.
    always_comb begin
        flush_mask = '0;
        offs       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = IDX_W'(i) - head_q;
            if (mispredict && (offs > keep_len)) flush_mask[i] = 1'b1;
        end
    end

    // Ordering below makes flush win over a same-edge completion.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q | (done_hits & valid_q);
        if (commit_valid) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
        end
        valid_d = valid_d & ~flush_mask;
        done_d  = done_d & ~flush_mask;
        if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
        end
        head_d = head_q + IDX_W'(commit_valid);
        if (mispredict) begin
            tail_d  = mispredict_tag + IDX_W'(1);
            count_d = keep_cnt - (IDX_W+1)'(commit_valid);
        end else begin
            tail_d  = tail_q + IDX_W'(alloc_fire);
            count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_valid);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload is only meaningful while valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_dest_q[tail_q] <= alloc_has_dest;
            rd_q[tail_q]       <= alloc_rd;
            pd_new_q[tail_q]   <= alloc_pd_new;
            pd_old_q[tail_q]   <= alloc_pd_old;
        end
    end

`ifdef ROB_STATS_EN
    logic [IDX_W:0] flushed_n;
    logic [32:0]    flush_sum;

    assign flushed_n = count_q - keep_cnt;
    assign flush_sum = {1'b0, stat_flushed} + 33'(flushed_n);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_commits <= '0;
            stat_flushed <= '0;
        end else begin
            if (commit_valid && (stat_commits != '1)) stat_commits <= stat_commits + 32'd1;
            if (mispredict) stat_flushed <= flush_sum[32] ? '1 : flush_sum[31:0];
        end
    end
`endif

    always @(posedge clk) begin
        if (reset_n) assert (!(alloc_en && rob_full)) else $warning("alloc_en ignored while rob_full");
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table, corner sequences and random
// traffic against a queue-based program-order model. Stats checked when ROB_STATS_EN is defined.
module tb_reorder_buffer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       alloc_en = 1'b0;
    logic [6:0] alloc_pd_new = '0, alloc_pd_old = '0;
    logic [4:0] alloc_rd = '0;
    logic       alloc_has_dest = 1'b0;
    logic       rob_full;
    logic [4:0] rob_index;
    logic       alu_done = 1'b0, b_done = 1'b0, mem_done = 1'b0;
    logic [4:0] alu_tag = '0, b_tag = '0, mem_tag = '0;
    logic       mispredict = 1'b0;
    logic [4:0] mispredict_tag = '0;
    logic       commit_valid, commit_free, rob_empty;
    logic [4:0] commit_rd;
    logic [6:0] commit_pd_new, commit_pd_old;
`ifdef ROB_STATS_EN
    logic [31:0] stat_commits, stat_flushed;
`endif

    reorder_buffer dut (
        .clk(clk), .reset_n(reset_n),
        .alloc_en(alloc_en), .alloc_pd_new(alloc_pd_new), .alloc_pd_old(alloc_pd_old),
        .alloc_rd(alloc_rd), .alloc_has_dest(alloc_has_dest),
        .rob_full(rob_full), .rob_index(rob_index),
        .alu_done(alu_done), .alu_tag(alu_tag), .b_done(b_done), .b_tag(b_tag),
        .mem_done(mem_done), .mem_tag(mem_tag),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_pd_new(commit_pd_new),
        .commit_pd_old(commit_pd_old), .commit_free(commit_free), .rob_empty(rob_empty)
`ifdef ROB_STATS_EN
        , .stat_commits(stat_commits), .stat_flushed(stat_flushed)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        bit         done;
        bit         hd;
        logic [4:0] rd;
        logic [6:0] pn;
        logic [6:0] po;
    } ent_t;

    ent_t q[$];
    int   m_head = 0;
    longint unsigned m_commits = 0, m_flushed = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        bit         alloc;
        bit         hd;
        logic [6:0] po;
        int         done_sel;
        int         done_tag;
        int         exp_index;
        bit         exp_empty;
        bit         exp_cv;
        bit         exp_cf;
    } vec_t;

    vec_t vecs[10];

    task automatic clear_inputs();
        alloc_en = 1'b0; alloc_has_dest = 1'b0;
        alloc_pd_new = '0; alloc_pd_old = '0; alloc_rd = '0;
        alu_done = 1'b0; b_done = 1'b0; mem_done = 1'b0;
        alu_tag = '0; b_tag = '0; mem_tag = '0;
        mispredict = 1'b0; mispredict_tag = '0;
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_output(input string name);
        logic [27:0] exp_v, act_v;
        bit e_cv, e_cf;
        logic [4:0] e_rd;
        logic [6:0] e_pn, e_po;
        e_cv = (q.size() > 0) && q[0].done;
        e_cf = 1'b0; e_rd = '0; e_pn = '0; e_po = '0;
        if (e_cv) begin
            e_rd = q[0].rd; e_pn = q[0].pn; e_po = q[0].po;
            e_cf = q[0].hd && (q[0].po != 0);
        end
        exp_v = {q.size() == 32, q.size() == 0, 5'((m_head + q.size()) % 32), e_cv, e_cf, e_rd, e_pn, e_po};
        act_v = {rob_full, rob_empty, rob_index, commit_valid, commit_free,
                 commit_valid ? commit_rd : 5'd0, commit_valid ? commit_pd_new : 7'd0,
                 commit_valid ? commit_pd_old : 7'd0};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s: got {full,empty,idx,cv,cf,rd,pn,po}=%h expected %h", name, act_v, exp_v);
        end
`ifdef ROB_STATS_EN
        check_val({name, "_stat_commits"}, int'(stat_commits), int'(m_commits));
        check_val({name, "_stat_flushed"}, int'(stat_flushed), int'(m_flushed));
`endif
    endtask

    // Program-order model: entries live in a queue, oldest first.
    task automatic model_edge();
        bit cv, was_full;
        int p;
        cv = (q.size() > 0) && q[0].done;
        was_full = (q.size() == 32);
        foreach (q[k]) begin
            if (alu_done && q[k].idx == int'(alu_tag)) q[k].done = 1'b1;
            if (b_done && q[k].idx == int'(b_tag)) q[k].done = 1'b1;
            if (mem_done && q[k].idx == int'(mem_tag)) q[k].done = 1'b1;
        end
        if (mispredict) begin
            p = -1;
            foreach (q[k]) if (q[k].idx == int'(mispredict_tag)) p = k;
            if (p >= 0) begin
                m_flushed += longint'(q.size() - (p + 1));
                while (q.size() > p + 1) void'(q.pop_back());
            end
        end
        if (cv) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % 32;
            m_commits++;
        end
        if (alloc_en && !mispredict && !was_full)
            q.push_back('{(m_head + q.size()) % 32, 1'b0, alloc_has_dest, alloc_rd, alloc_pd_new, alloc_pd_old});
    endtask

    task automatic apply_stimulus(input string name);
        check_output(name);
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        #1;
        q.delete(); m_head = 0; m_commits = 0; m_flushed = 0;
        check_output("reset");
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic alloc_one(input logic [6:0] pn, input logic [6:0] po, input bit hd);
        alloc_en = 1'b1; alloc_pd_new = pn; alloc_pd_old = po; alloc_has_dest = hd;
        alloc_rd = pn[4:0];
    endtask

    initial begin
        vecs[0] = '{1, 1, 7'd20, 0, 0, 0, 1, 0, 0};
        vecs[1] = '{1, 0, 7'd21, 0, 0, 1, 0, 0, 0};
        vecs[2] = '{1, 1, 7'd0,  0, 0, 2, 0, 0, 0};
        vecs[3] = '{0, 0, 7'd0,  1, 2, 3, 0, 0, 0};
        vecs[4] = '{0, 0, 7'd0,  2, 1, 3, 0, 0, 0};
        vecs[5] = '{0, 0, 7'd0,  3, 0, 3, 0, 0, 0};
        vecs[6] = '{0, 0, 7'd0,  0, 0, 3, 0, 1, 1};
        vecs[7] = '{0, 0, 7'd0,  0, 0, 3, 0, 1, 0};
        vecs[8] = '{0, 0, 7'd0,  0, 0, 3, 0, 1, 0};
        vecs[9] = '{0, 0, 7'd0,  0, 0, 3, 1, 0, 0};

        @(negedge clk);
        do_reset();
        apply_stimulus("idle");

        // Out-of-order completion, in-order retirement
        foreach (vecs[i]) begin
            clear_inputs();
            if (vecs[i].alloc) alloc_one(7'(10 + i), vecs[i].po, vecs[i].hd);
            alu_done = (vecs[i].done_sel == 1);
            b_done   = (vecs[i].done_sel == 2);
            mem_done = (vecs[i].done_sel == 3);
            alu_tag = 5'(vecs[i].done_tag); b_tag = alu_tag; mem_tag = alu_tag;
            check_val($sformatf("vec%0d", i),
                      int'({rob_index, rob_empty, commit_valid, commit_free}),
                      int'({5'(vecs[i].exp_index), vecs[i].exp_empty, vecs[i].exp_cv, vecs[i].exp_cf}));
            apply_stimulus($sformatf("vec%0d_model", i));
        end

        // Fill to full, then one ignored allocation
        do_reset();
        for (int i = 0; i < 32; i++) begin
            clear_inputs();
            alloc_one(7'(i + 1), 7'(i + 40), 1'b1);
            apply_stimulus("fill");
        end
        check_val("full_after_32", int'(rob_full), 1);
        check_val("index_wrapped", int'(rob_index), 0);
        clear_inputs();
        alloc_one(7'd99, 7'd98, 1'b1);
        apply_stimulus("alloc_when_full");
        check_val("full_still", int'(rob_full), 1);
        clear_inputs();
        alu_done = 1'b1; alu_tag = 5'd0;
        apply_stimulus("complete_head_full");
        check_val("head_pd_new", int'(commit_pd_new), 1);
        clear_inputs();
        apply_stimulus("retire_from_full");

        // Mispredict flush with a dropped same-cycle allocation
        do_reset();
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            alloc_one(7'(i + 60), 7'(i + 1), 1'b1);
            apply_stimulus("alloc6");
        end
        clear_inputs();
        mispredict = 1'b1; mispredict_tag = 5'd2;
        alloc_one(7'd77, 7'd5, 1'b1);
        apply_stimulus("mispredict2");
        check_val("tail_after_flush", int'(rob_index), 3);
        clear_inputs();
        alu_done = 1'b1; alu_tag = 5'd4; b_done = 1'b1; b_tag = 5'd5;
        apply_stimulus("late_complete_flushed");
        clear_inputs();
        alloc_one(7'd80, 7'd3, 1'b0);
        check_val("realloc_index", int'(rob_index), 3);
        apply_stimulus("realloc");
        clear_inputs();
        alu_done = 1'b1; alu_tag = 5'd0; b_done = 1'b1; b_tag = 5'd1; mem_done = 1'b1; mem_tag = 5'd2;
        apply_stimulus("complete012");
        clear_inputs();
        alu_done = 1'b1; alu_tag = 5'd3;
        apply_stimulus("complete3");
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            apply_stimulus("drain_flush");
        end
        check_val("drained_after_flush", int'(rob_empty), 1);

        // Wrap-around flush with head committing on the same edge
        do_reset();
        for (int i = 0; i < 30; i++) begin
            clear_inputs();
            alloc_one(7'(i + 1), 7'(i + 2), 1'(i % 2));
            alu_done = (i > 0); alu_tag = 5'(i - 1);
            apply_stimulus("advance");
        end
        clear_inputs();
        alu_done = 1'b1; alu_tag = 5'd29;
        apply_stimulus("advance_last");
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            apply_stimulus("advance_drain");
        end
        check_val("head_at_30", int'(rob_index), 30);
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            alloc_one(7'(i + 100), 7'(i), 1'b1);
            apply_stimulus("wrap_alloc");
        end
        check_val("tail_wrapped", int'(rob_index), 4);
        clear_inputs();
        alu_done = 1'b1; alu_tag = 5'd30;
        apply_stimulus("complete30");
        clear_inputs();
        mispredict = 1'b1; mispredict_tag = 5'd1;
        check_val("commit_with_flush", int'(commit_valid), 1);
        apply_stimulus("wrap_mispredict");
        check_val("tail_after_wrap_flush", int'(rob_index), 2);
        clear_inputs();
        alu_done = 1'b1; alu_tag = 5'd31; b_done = 1'b1; b_tag = 5'd0; mem_done = 1'b1; mem_tag = 5'd1;
        apply_stimulus("complete_rest");
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            apply_stimulus("wrap_drain");
        end
        check_val("wrap_empty", int'(rob_empty), 1);

        // Two buses on the head tag, commit+alloc, then asynchronous reset mid-stream
        do_reset();
        clear_inputs();
        alloc_one(7'd11, 7'd12, 1'b1);
        apply_stimulus("same_alloc0");
        clear_inputs();
        alloc_one(7'd13, 7'd14, 1'b1);
        alu_done = 1'b1; alu_tag = 5'd0; mem_done = 1'b1; mem_tag = 5'd0;
        apply_stimulus("dual_done_head");
        clear_inputs();
        alloc_one(7'd15, 7'd0, 1'b1);
        check_val("head_ready", int'(commit_valid), 1);
        apply_stimulus("commit_plus_alloc");
        clear_inputs();
        alloc_one(7'd17, 7'd18, 1'b0);
        b_done = 1'b1; b_tag = 5'd1;
        apply_stimulus("pre_reset");
        clear_inputs();
        reset_n = 1'b0;
        #1;
        check_val("async_reset_empty", int'(rob_empty), 1);
        check_val("async_reset_index", int'(rob_index), 0);
        q.delete(); m_head = 0; m_commits = 0; m_flushed = 0;
        check_output("async_reset");
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            clear_inputs();
            if (q.size() < 32 && $urandom_range(0, 99) < 60)
                alloc_one(7'($urandom_range(0, 127)), 7'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 127)),
                          1'($urandom_range(0, 1)));
            alu_done = ($urandom_range(0, 99) < 40);
            b_done   = ($urandom_range(0, 99) < 30);
            mem_done = ($urandom_range(0, 99) < 30);
            alu_tag = (q.size() > 0 && $urandom_range(0, 9) < 8) ? 5'(q[$urandom_range(0, q.size() - 1)].idx)
                                                                 : 5'($urandom_range(0, 31));
            b_tag   = (q.size() > 0 && $urandom_range(0, 9) < 8) ? 5'(q[$urandom_range(0, q.size() - 1)].idx)
                                                                 : 5'($urandom_range(0, 31));
            mem_tag = (q.size() > 0) ? 5'(q[$urandom_range(0, q.size() - 1)].idx) : 5'($urandom_range(0, 31));
            if (q.size() > 0 && $urandom_range(0, 99) < 4) begin
                mispredict = 1'b1;
                mispredict_tag = 5'(q[$urandom_range(0, q.size() - 1)].idx);
            end
            apply_stimulus("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
